riscv_mc_ctrl_alu: RTL and testbench
====================================

Name: riscv_mc_ctrl_alu

Overview:
Control-and-execute core of the multi-cycle RV32I CPU. It combines the main control FSM, the ALU-operation decoder and the 32-bit ALU. It decodes the current instruction word and sequences each instruction through IF/ID/EX/MEM/WB. Every cycle it produces the datapath control strobes, the ALU result and the branch-condition flag. Register file, memories, immediate generator and PC register stay outside the block.

Parameters:
none

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  reset
INSTR  in  32  current instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
PC  in  32  current PC
RS1_DATA  in  32  register-file read data 1
RS2_DATA  in  32  register-file read data 2
IMM  in  32  sign-extended immediate from the external generator
ALU_RESULT  out  32  ALU output
ZERO  out  1  branch-condition / zero flag
ALU_OPERATION  out  5  decoded ALU code
STATE  out  3  FSM state: IF=0, ID=1, EX=2, MEM=3, WB=4
REG_DST, JUMP, BRANCH, MEM_READ, MEM_TO_REG, MEM_WRITE, ALU_SRC1, ALU_SRC2, REG_WRITE, JAL_OR_JALR, PC_WRITE  out  1 each  control strobes
ALU_OP  out  7  equals INSTR[6:0]
BE  out  4  byte enables
CONCAT_CONTROL  out  3  immediate type: I=0, S=1, B=2, U=3, J=4

Behaviour:
- Reset is synchronous and active-high.
  - RST high at a rising CLK edge: STATE goes to IF.
  - While STATE is IF, REG_WRITE, MEM_WRITE and PC_WRITE are 0.
  - Reset mid-instruction aborts the instruction; no write strobe fires in the cycle after reset.
- FSM paths by opcode (PC_WRITE is high only in the final state of each path):
  - R-type 0110011, I-ALU 0010011, LUI 0110111, AUIPC 0010111: IF, ID, EX, WB. REG_WRITE in WB.
  - Load 0000011: IF, ID, EX, MEM, WB. REG_WRITE and MEM_TO_REG in WB.
  - Store 0100011: IF, ID, EX, MEM. MEM_WRITE in MEM.
  - Branch 1100011: IF, ID, EX.
  - JAL 1101111 and JALR 1100111: IF, ID, EX. REG_WRITE in EX.
  - Any other opcode: IF, ID, EX with no writes; acts as a NOP.
- After the final state the FSM returns to IF. PC_WRITE is therefore a one-cycle pulse per instruction.
- Level decode signals, combinational from INSTR and valid in every state:
  - MEM_READ=1 and REG_DST=1 always.
  - JUMP=1 for JAL and JALR. JAL_OR_JALR=1 for JALR only.
  - BRANCH=1 for branches.
  - ALU_SRC1=1 (PC operand) for AUIPC and JAL.
  - ALU_SRC2=1 (IMM operand) for every opcode except R-type and branch.
- BE is set for loads and stores only, by funct3[1:0]:
  - 00 → 0001
  - 01 → 0011
  - 1x → 1111
  - All other opcodes: 1111.
- CONCAT_CONTROL by opcode:
  - I-type (loads, I-ALU, JALR) → 0
  - Store → 1
  - Branch → 2
  - LUI / AUIPC → 3
  - JAL → 4
- ALU operands: A = ALU_SRC1 ? PC : RS1_DATA; B = ALU_SRC2 ? IMM : RS2_DATA. The ALU is purely combinational.
- ALU_OPERATION codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
  - 11 BEQ, 12 BNE, 13 BLT, 14 BGE, 15 BLTU, 16 BGEU
- ALU_OPERATION decode:
  - R-type: by funct3. funct7[5] selects SUB for funct3=000 and SRA for funct3=101.
  - I-ALU: same as R-type, but funct3=000 is always ADD; funct7[5] is honoured only for funct3=101.
  - Branch: funct3 000/001/100/101/110/111 → BEQ/BNE/BLT/BGE/BLTU/BGEU. Branch funct3 010/011 → BEQ.
  - LUI → PASSB.
  - All other opcodes → ADD.
- ALU arithmetic:
  - Results are modulo 2^32.
  - Shift amount is B[4:0].
  - SLT and SLTU return 1 or 0 (signed and unsigned compare).
  - Branch codes output ALU_RESULT = A−B.
- ZERO:
  - Branch codes: ZERO = the comparison outcome (e.g. BNE gives ZERO=1 when A≠B).
  - All other codes: ZERO = (ALU_RESULT == 0).

Test Plan:
- RST high for 2 cycles, then ADD x3,x1,x2 (0x002081B3) with RS1=5, RS2=7:
  - STATE goes 0,1,2,4.
  - ALU_RESULT=12.
  - REG_WRITE and PC_WRITE are high only in WB.
- LW (opcode 0000011, funct3=010) with RS1=0x100, IMM=8:
  - 5 states; ALU_RESULT=0x108, BE=1111, CONCAT_CONTROL=0.
  - MEM_TO_REG=1 and REG_WRITE=1 in WB.
- SB (funct3=000) with RS1=0x20, IMM=3:
  - BE=0001, ALU_RESULT=0x23.
  - MEM_WRITE=1 only in MEM; PC_WRITE in MEM; 4 states total.
- BNE with RS1=1, RS2=1, then with RS1=1, RS2=2:
  - ZERO=0, then ZERO=1.
  - BRANCH=1; PC_WRITE in EX; 3 states.
- JALR with RS1=0x41, IMM=0:
  - JUMP=1, JAL_OR_JALR=1, ALU_RESULT=0x41.
  - REG_WRITE and PC_WRITE in EX.
- SRAI by 4 on 0x80000000 → 0xF8000000. SLTU 0xFFFFFFFF,1 → 0. RST asserted during EX of a store → MEM_WRITE never pulses.

Source files
------------

// File: rtl/riscv_mc_ctrl_alu.sv
// Multi-cycle RV32I control-and-execute core: main FSM, ALU-operation decoder and 32-bit ALU.
// Control strobes derive from the registered state; ALU and level decode are combinational.
module riscv_mc_ctrl_alu (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTR,
  input  logic [31:0] PC,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] IMM,
  output logic [31:0] ALU_RESULT,
  output logic        ZERO,
  output logic [4:0]  ALU_OPERATION,
  output logic [2:0]  STATE,
  output logic        REG_DST,
  output logic        JUMP,
  output logic        BRANCH,
  output logic        MEM_READ,
  output logic        MEM_TO_REG,
  output logic        MEM_WRITE,
  output logic        ALU_SRC1,
  output logic        ALU_SRC2,
  output logic        REG_WRITE,
  output logic        JAL_OR_JALR,
  output logic        PC_WRITE,
  output logic [6:0]  ALU_OP,
  output logic [3:0]  BE,
  output logic [2:0]  CONCAT_CONTROL
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_BEQ   = 5'd11;
  localparam logic [4:0] ALU_BNE   = 5'd12;
  localparam logic [4:0] ALU_BLT   = 5'd13;
  localparam logic [4:0] ALU_BGE   = 5'd14;
  localparam logic [4:0] ALU_BLTU  = 5'd15;
  localparam logic [4:0] ALU_BGEU  = 5'd16;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_jump;
  logic        w_wb_path;
  logic [4:0]  w_alu_operation;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_diff;
  logic [31:0] w_result;
  logic        w_zero;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_pc_write;
  logic        w_mem_to_reg;

  // Register/immediate ALU ops share the funct3 map; only R-type lets funct7[5] pick SUB.
  function automatic logic [4:0] f_arith_op(input logic [2:0] funct3, input logic alt,
                                            input logic allow_sub);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] f_branch_op(input logic [2:0] funct3);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = ALU_BEQ;
      3'b001:  op = ALU_BNE;
      3'b100:  op = ALU_BLT;
      3'b101:  op = ALU_BGE;
      3'b110:  op = ALU_BLTU;
      3'b111:  op = ALU_BGEU;
      default: op = ALU_BEQ;
    endcase
    return op;
  endfunction

  assign w_opcode   = INSTR[6:0];
  assign w_funct3   = INSTR[14:12];
  assign w_funct7_5 = INSTR[30];
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_is_jump  = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);
  assign w_wb_path  = (w_opcode == OP_RTYPE) || (w_opcode == OP_IALU) ||
                      (w_opcode == OP_LUI)   || (w_opcode == OP_AUIPC);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and write strobes; PC_WRITE fires in the last state of each path.
  always_comb begin
    w_next_state = ST_IF;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_pc_write   = 1'b0;
    w_mem_to_reg = 1'b0;
    case (r_state)
      ST_IF: begin
        w_next_state = ST_ID;
      end
      ST_ID: begin
        w_next_state = ST_EX;
      end
      ST_EX: begin
        if (w_wb_path) begin
          w_next_state = ST_WB;
        end else if (w_is_load || w_is_store) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_IF;
          w_pc_write   = 1'b1;
          w_reg_write  = w_is_jump;
        end
      end
      ST_MEM: begin
        if (w_is_load) begin
          w_next_state = ST_WB;
        end else begin
          w_next_state = ST_IF;
          w_pc_write   = 1'b1;
          w_mem_write  = w_is_store;
        end
      end
      ST_WB: begin
        w_next_state = ST_IF;
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_mem_to_reg = w_is_load;
      end
      default: begin
        w_next_state = ST_IF;
      end
    endcase
  end

  // Level decode from the instruction word, valid in every state.
  always_comb begin
    JUMP            = w_is_jump;
    JAL_OR_JALR     = (w_opcode == OP_JALR);
    BRANCH          = (w_opcode == OP_BRANCH);
    ALU_SRC1        = (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL);
    ALU_SRC2        = !((w_opcode == OP_RTYPE) || (w_opcode == OP_BRANCH));
    BE              = 4'b1111;
    CONCAT_CONTROL  = 3'd0;
    w_alu_operation = ALU_ADD;
    if (w_is_load || w_is_store) begin
      if (w_funct3[1]) begin
        BE = 4'b1111;
      end else if (w_funct3[0]) begin
        BE = 4'b0011;
      end else begin
        BE = 4'b0001;
      end
    end else begin
      BE = 4'b1111;
    end
    case (w_opcode)
      OP_RTYPE:  w_alu_operation = f_arith_op(w_funct3, w_funct7_5, 1'b1);
      OP_IALU:   w_alu_operation = f_arith_op(w_funct3, w_funct7_5, 1'b0);
      OP_BRANCH: w_alu_operation = f_branch_op(w_funct3);
      OP_LUI:    w_alu_operation = ALU_PASSB;
      default:   w_alu_operation = ALU_ADD;
    endcase
    case (w_opcode)
      OP_STORE:  CONCAT_CONTROL = 3'd1;
      OP_BRANCH: CONCAT_CONTROL = 3'd2;
      OP_LUI:    CONCAT_CONTROL = 3'd3;
      OP_AUIPC:  CONCAT_CONTROL = 3'd3;
      OP_JAL:    CONCAT_CONTROL = 3'd4;
      default:   CONCAT_CONTROL = 3'd0;
    endcase
  end

  assign w_a    = ALU_SRC1 ? PC : RS1_DATA;
  assign w_b    = ALU_SRC2 ? IMM : RS2_DATA;
  assign w_diff = w_a - w_b;

  // ALU datapath; branch codes report A-B and put the compare outcome on ZERO.
  always_comb begin
    w_result = w_a + w_b;
    w_zero   = 1'b0;
    case (w_alu_operation)
      ALU_ADD:   w_result = w_a + w_b;
      ALU_SUB:   w_result = w_diff;
      ALU_SLL:   w_result = w_a << w_b[4:0];
      ALU_SLT:   w_result = {31'd0, ($signed(w_a) < $signed(w_b))};
      ALU_SLTU:  w_result = {31'd0, (w_a < w_b)};
      ALU_XOR:   w_result = w_a ^ w_b;
      ALU_SRL:   w_result = w_a >> w_b[4:0];
      ALU_SRA:   w_result = $unsigned($signed(w_a) >>> w_b[4:0]);
      ALU_OR:    w_result = w_a | w_b;
      ALU_AND:   w_result = w_a & w_b;
      ALU_PASSB: w_result = w_b;
      default:   w_result = w_diff;
    endcase
    case (w_alu_operation)
      ALU_BEQ:  w_zero = (w_a == w_b);
      ALU_BNE:  w_zero = (w_a != w_b);
      ALU_BLT:  w_zero = ($signed(w_a) < $signed(w_b));
      ALU_BGE:  w_zero = ($signed(w_a) >= $signed(w_b));
      ALU_BLTU: w_zero = (w_a < w_b);
      ALU_BGEU: w_zero = (w_a >= w_b);
      default:  w_zero = (w_result == 32'd0);
    endcase
  end

  assign ALU_RESULT    = w_result;
  assign ZERO          = w_zero;
  assign ALU_OPERATION = w_alu_operation;
  assign STATE         = r_state;
  assign ALU_OP        = w_opcode;
  assign MEM_READ      = 1'b1;
  assign REG_DST       = 1'b1;
  assign REG_WRITE     = w_reg_write;
  assign MEM_WRITE     = w_mem_write;
  assign PC_WRITE      = w_pc_write;
  assign MEM_TO_REG    = w_mem_to_reg;

endmodule

// File: tb/tb_riscv_mc_ctrl_alu.sv
// Scoreboard bench for riscv_mc_ctrl_alu: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_riscv_mc_ctrl_alu;

  logic        CLK;
  logic        RST;
  logic [31:0] INSTR, PC, RS1_DATA, RS2_DATA, IMM;
  logic [31:0] ALU_RESULT;
  logic        ZERO;
  logic [4:0]  ALU_OPERATION;
  logic [2:0]  STATE;
  logic        REG_DST, JUMP, BRANCH, MEM_READ, MEM_TO_REG, MEM_WRITE;
  logic        ALU_SRC1, ALU_SRC2, REG_WRITE, JAL_OR_JALR, PC_WRITE;
  logic [6:0]  ALU_OP;
  logic [3:0]  BE;
  logic [2:0]  CONCAT_CONTROL;

  riscv_mc_ctrl_alu dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .PC(PC), .RS1_DATA(RS1_DATA),
    .RS2_DATA(RS2_DATA), .IMM(IMM), .ALU_RESULT(ALU_RESULT), .ZERO(ZERO),
    .ALU_OPERATION(ALU_OPERATION), .STATE(STATE), .REG_DST(REG_DST), .JUMP(JUMP),
    .BRANCH(BRANCH), .MEM_READ(MEM_READ), .MEM_TO_REG(MEM_TO_REG),
    .MEM_WRITE(MEM_WRITE), .ALU_SRC1(ALU_SRC1), .ALU_SRC2(ALU_SRC2),
    .REG_WRITE(REG_WRITE), .JAL_OR_JALR(JAL_OR_JALR), .PC_WRITE(PC_WRITE),
    .ALU_OP(ALU_OP), .BE(BE), .CONCAT_CONTROL(CONCAT_CONTROL)
  );

  typedef struct {
    logic [2:0]  st;
    logic [31:0] res;
    logic        zero;
    logic [3:0]  wr;   // {REG_WRITE, MEM_WRITE, PC_WRITE, MEM_TO_REG}
    logic [4:0]  dec;  // {JUMP, JAL_OR_JALR, BRANCH, ALU_SRC1, ALU_SRC2}
    logic [3:0]  be;
    int          cc;   // -1: not checked
    int          op;
    logic [6:0]  alu_op;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;

  logic [31:0] e_res;
  logic        e_zero;
  logic [4:0]  e_dec;
  logic [3:0]  e_be;
  int          e_cc;
  int          e_op;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents a new control/ALU vector every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", {29'd0, STATE}, {29'd0, e.st});
        chk("alu_result", ALU_RESULT, e.res);
        chk("zero", {31'd0, ZERO}, {31'd0, e.zero});
        chk("strobes", {28'd0, REG_WRITE, MEM_WRITE, PC_WRITE, MEM_TO_REG}, {28'd0, e.wr});
        chk("decode", {27'd0, JUMP, JAL_OR_JALR, BRANCH, ALU_SRC1, ALU_SRC2}, {27'd0, e.dec});
        chk("be", {28'd0, BE}, {28'd0, e.be});
        chk("alu_operation", {27'd0, ALU_OPERATION}, e.op);
        chk("fixed", {23'd0, ALU_OP, MEM_READ, REG_DST}, {23'd0, e.alu_op, 1'b1, 1'b1});
        if (e.cc >= 0) begin
          chk("concat_control", {29'd0, CONCAT_CONTROL}, e.cc);
        end
      end
    end
  end

  task automatic setup(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] res, input logic zero,
                       input logic [4:0] dec, input logic [3:0] be, input int cc, input int op);
    INSTR = instr; RS1_DATA = rs1; RS2_DATA = rs2; IMM = imm;
    e_res = res; e_zero = zero; e_dec = dec; e_be = be; e_cc = cc; e_op = op;
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input logic [2:0] st, input logic [3:0] wr);
    exp_t e;
    e.st = st; e.res = e_res; e.zero = e_zero; e.wr = wr; e.dec = e_dec;
    e.be = e_be; e.cc = e_cc; e.op = e_op; e.alu_op = INSTR[6:0];
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    PC = 32'h0000_1000;
    RST = 1'b1;
    setup(32'h002081B3, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 5'b00000, 4'b1111, -1, 0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    // ADD x3,x1,x2: 5+7
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0000); cyc(3'd4, 4'b1010);
    // LW x5,8(x1)
    setup(32'h0080A283, 32'h100, 32'd0, 32'd8, 32'h108, 1'b0, 5'b00001, 4'b1111, 0, 0);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0000); cyc(3'd3, 4'b0000);
    cyc(3'd4, 4'b1011);
    // SB x2,3(x1)
    setup(32'h002081A3, 32'h20, 32'd0, 32'd3, 32'h23, 1'b0, 5'b00001, 4'b0001, 1, 0);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0000); cyc(3'd3, 4'b0110);
    // BNE equal operands: not taken
    setup(32'h00209063, 32'd1, 32'd1, 32'd16, 32'd0, 1'b0, 5'b00100, 4'b1111, 2, 12);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0010);
    // BNE 1 vs 2: taken, result 1-2
    setup(32'h00209063, 32'd1, 32'd2, 32'd16, 32'hFFFF_FFFF, 1'b1, 5'b00100, 4'b1111, 2, 12);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0010);
    // JALR x1,0(x1)
    setup(32'h000080E7, 32'h41, 32'd0, 32'd0, 32'h41, 1'b0, 5'b11001, 4'b1111, 0, 0);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b1010);
    // SRAI x1,x1,4 on 0x80000000
    setup(32'h4040D093, 32'h8000_0000, 32'd0, 32'h404, 32'hF800_0000, 1'b0, 5'b00001,
          4'b1111, 0, 7);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0000); cyc(3'd4, 4'b1010);
    // SLTU 0xFFFFFFFF < 1 is false
    setup(32'h0020B1B3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 5'b00000, 4'b1111, -1, 4);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0000); cyc(3'd4, 4'b1010);
    // LUI passes the immediate
    setup(32'h123450B7, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 32'h1234_5000, 1'b0, 5'b00001,
          4'b1111, 3, 10);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0000); cyc(3'd4, 4'b1010);
    // Unknown opcode acts as a NOP: three states, no writes
    setup(32'h0000_0000, 32'd3, 32'd9, 32'd4, 32'd7, 1'b0, 5'b00001, 4'b1111, -1, 0);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0010);
    // SB aborted by reset during EX: no MEM_WRITE afterwards
    setup(32'h002081A3, 32'h20, 32'd0, 32'd3, 32'h23, 1'b0, 5'b00001, 4'b0001, 1, 0);
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000);
    RST = 1'b1;
    cyc(3'd2, 4'b0000);
    RST = 1'b0;
    cyc(3'd0, 4'b0000); cyc(3'd1, 4'b0000); cyc(3'd2, 4'b0000); cyc(3'd3, 4'b0110);

    repeat (3) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
